// File: rtl/pixel_frame_collector.sv
// pixel_frame_collector: deserializes a valid/ready pixel stream into ping-pong frame banks
// and presents one complete frame in parallel, flagging frames whose pix_last is misaligned.
module pixel_frame_collector #(
    parameter int PARAM_IN_CNT = 784,
    parameter int PARAM_IN_BIT = 2,
    parameter int PARAM_ERR_W  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        pix_valid,
    input  logic [PARAM_IN_BIT-1:0]                     pix_data,
    input  logic                                        pix_last,
    output logic                                        pix_ready,
    output logic                                        frame_valid,
    output logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0]   frame_data,
    input  logic                                        frame_ready,
    output logic                                        frame_err,
    output logic [PARAM_ERR_W-1:0]                      err_cnt
);
    localparam int CW = $clog2(PARAM_IN_CNT);
    localparam logic [CW-1:0] LAST_POS = CW'(PARAM_IN_CNT - 1);

    typedef enum logic {FILL, DROP} state_t;

    state_t                                     r_state, w_state_nxt;
    logic [CW-1:0]                              r_wr_cnt, w_wr_cnt_nxt;
    logic                                       r_wr_sel, r_rd_sel;
    logic [1:0]                                 r_full, w_full_nxt;
    logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0]  r_bank [2];
    logic                                       r_err, w_err_nxt;
    logic [PARAM_ERR_W-1:0]                     r_err_cnt;
    logic                                       w_accept, w_release, w_complete, w_at_last;

    // Ready depends on registers only, so a release frees the bank one cycle later.
    assign pix_ready   = (r_state == DROP) | ~r_full[r_wr_sel];
    assign w_accept    = pix_valid & pix_ready;
    assign frame_valid = r_full[r_rd_sel];
    assign frame_data  = r_bank[r_rd_sel];
    assign w_release   = frame_valid & frame_ready;
    assign w_at_last   = (r_wr_cnt == LAST_POS);
    assign frame_err   = r_err;
    assign err_cnt     = r_err_cnt;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_err_nxt    = 1'b0;
        w_complete   = 1'b0;
        if (w_accept) begin
            if (r_state == DROP) begin
                w_state_nxt  = pix_last ? FILL : DROP;
                w_wr_cnt_nxt = '0;
            end else if (!w_at_last) begin
                w_wr_cnt_nxt = pix_last ? '0 : r_wr_cnt + 1'b1;
                w_err_nxt    = pix_last;
            end else begin
                w_wr_cnt_nxt = '0;
                w_complete   = pix_last;
                w_err_nxt    = ~pix_last;
                w_state_nxt  = pix_last ? FILL : DROP;
            end
        end
        w_full_nxt = r_full;
        if (w_release)
            w_full_nxt[r_rd_sel] = 1'b0;
        if (w_complete)
            w_full_nxt[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= FILL;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_full    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_bank    <= '{default: '0};
        end else begin
            r_wr_cnt <= w_wr_cnt_nxt;
            r_full   <= w_full_nxt;
            r_err    <= w_err_nxt;
            if (w_complete)
                r_wr_sel <= ~r_wr_sel;
            if (w_release)
                r_rd_sel <= ~r_rd_sel;
            if (w_err_nxt && !(&r_err_cnt))
                r_err_cnt <= r_err_cnt + 1'b1;
            if (w_accept && r_state == FILL)
                r_bank[r_wr_sel][r_wr_cnt] <= pix_data;
        end
    end
endmodule

// File: tb/tb_pixel_frame_collector.sv
// tb_pixel_frame_collector: directed scenarios plus random streaming, checked every cycle
// against a frame-queue model of the collector.
module tb_pixel_frame_collector;
    localparam int CNT = 4;
    localparam int BIT = 2;
    localparam int EW  = 2;

    logic                     clk, rst;
    logic                     pix_valid, pix_last, pix_ready;
    logic [BIT-1:0]           pix_data;
    logic                     frame_valid, frame_ready, frame_err;
    logic [CNT-1:0][BIT-1:0]  frame_data;
    logic [EW-1:0]            err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_frames = 0;

    logic [CNT*BIT-1:0] m_q[$];
    logic [CNT*BIT-1:0] m_frame;
    int                 m_cnt, m_ecnt;
    logic               m_drop, m_err;

    pixel_frame_collector #(.PARAM_IN_CNT(CNT), .PARAM_IN_BIT(BIT), .PARAM_ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .pix_ready(pix_ready), .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_ready(frame_ready), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_ready();
        return m_drop || m_q.size() < 2;
    endfunction

    function automatic int m_sat();
        return m_ecnt > (1 << EW) - 1 ? (1 << EW) - 1 : m_ecnt;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_frame = '0;
        m_cnt = 0;
        m_ecnt = 0;
        m_drop = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [BIT-1:0] d, input logic l, input logic fr);
        logic acc;
        acc = v && m_ready();
        m_err = 1'b0;
        if (fr && m_q.size() > 0) begin
            void'(m_q.pop_front());
            n_frames++;
        end
        if (acc) begin
            if (m_drop) begin
                if (l) m_drop = 1'b0;
            end else begin
                m_frame[m_cnt*BIT +: BIT] = d;
                m_cnt++;
                if (m_cnt < CNT) begin
                    if (l) begin
                        m_err = 1'b1;
                        m_ecnt++;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                    if (l) m_q.push_back(m_frame);
                    else begin
                        m_err = 1'b1;
                        m_ecnt++;
                        m_drop = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("pix_ready", 64'(pix_ready), 64'(m_ready()));
        chk("frame_valid", 64'(frame_valid), 64'(m_q.size() > 0));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("err_cnt", 64'(err_cnt), 64'(m_sat()));
        if (m_q.size() > 0)
            chk("frame_data", 64'(frame_data), 64'(m_q[0]));
    endtask

    task automatic cycle(input logic v, input logic [BIT-1:0] d, input logic l, input logic fr,
                         output logic acc);
        @(negedge clk);
        check_outs();
        pix_valid = v;
        pix_data = d;
        pix_last = l;
        frame_ready = fr;
        acc = v && m_ready();
        @(posedge clk);
        model_step(v, d, l, fr);
    endtask

    task automatic idle(input int n, input logic fr);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, fr, acc);
    endtask

    task automatic send_pix(input logic [BIT-1:0] d, input logic l, input logic fr);
        logic acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, l, fr, acc);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("pix_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_frame(input int base, input logic fr);
        for (int k = 0; k < CNT; k++) send_pix(BIT'(base + k), k == CNT - 1, fr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        frame_ready = 1'b0;
        #1;
        chk("rst_pix_ready", 64'(pix_ready), 64'd1);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame_data", 64'(frame_data), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_data = '0;
        pix_last = 1'b0;
        frame_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Single frame, consumer always ready
        do_reset();
        send_frame(0, 1'b1);
        #1;
        chk("s1_valid", 64'(frame_valid), 64'd1);
        chk("s1_data", 64'(frame_data), 64'hE4);
        idle(3, 1'b1);
        chk("s1_err_cnt", 64'(err_cnt), 64'd0);

        // Three frames with the consumer stalled, then drained in order
        do_reset();
        send_frame(0, 1'b0);
        send_frame(1, 1'b0);
        #1;
        chk("s2_ready_low", 64'(pix_ready), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 1'b0, 1'b0, acc);
        chk("s2_hold_data", 64'(frame_data), 64'hE4);
        send_frame(2, 1'b1);
        idle(6, 1'b1);

        // Early last then a good frame
        do_reset();
        send_pix(2'd0, 1'b0, 1'b1);
        send_pix(2'd1, 1'b1, 1'b1);
        #1;
        chk("s3_err_pulse", 64'(frame_err), 64'd1);
        chk("s3_err_cnt", 64'(err_cnt), 64'd1);
        send_frame(4, 1'b1);
        #1;
        chk("s3_data", 64'(frame_data), 64'hE4);
        idle(3, 1'b1);

        // Missing last, dropped tail, then a good frame
        do_reset();
        for (int k = 0; k < CNT; k++) send_pix(2'(k), 1'b0, 1'b1);
        send_pix(2'd3, 1'b0, 1'b1);
        send_pix(2'd3, 1'b1, 1'b1);
        send_frame(1, 1'b1);
        #1;
        chk("s4_data", 64'(frame_data), 64'h39);
        chk("s4_err_cnt", 64'(err_cnt), 64'd1);
        idle(3, 1'b1);

        // Reset mid-frame with a frame pending
        do_reset();
        send_frame(0, 1'b0);
        send_pix(2'd1, 1'b0, 1'b0);
        send_pix(2'd2, 1'b0, 1'b0);
        do_reset();
        send_frame(3, 1'b1);
        idle(3, 1'b1);

        // Error counter saturation
        do_reset();
        for (int e = 0; e < 5; e++) send_pix(2'(e), 1'b1, 1'b1);
        #1;
        chk("s6_err_sat", 64'(err_cnt), 64'd3);
        idle(2, 1'b1);

        // Random streaming
        do_reset();
        n_frames = 0;
        for (int i = 0; i < 4000; i++) begin
            logic v, l, fr;
            logic [BIT-1:0] d;
            v = ($urandom % 4) != 0;
            d = BIT'($urandom);
            l = ($urandom % 12 == 0) ? 1'($urandom) : (!m_drop && m_cnt == CNT - 1);
            if (m_drop && $urandom % 3 == 0) l = 1'b1;
            fr = ($urandom % 3) != 0;
            cycle(v, d, l, fr, acc);
            if (i == 2000) do_reset();
        end
        idle(4, 1'b1);
        chk("rand_frames_seen", 64'(n_frames > 50), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
